// File: rtl/sram_ctl_pkg.sv
// Shared widths, FSM state encoding and the burst range check for the SRAM burst controller.
// Ports: none (package). ROW_LSB marks where the row field starts above the bank field.
// The range check flags a burst whose last beat carries out of the address or lands beyond ROWS.
package sram_ctl_pkg;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 256;
  localparam int BANK_W  = 5;
  localparam int ROW_LSB = BANK_W;
  localparam int LEN_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_RESP
  } state_t;

  // The last beat address is formed one bit wider so a carry out of the
  // 23-bit space is visible rather than silently wrapping to row 0.
  function automatic logic range_err(input logic [ADDR_W-1:0] addr,
                                     input logic [LEN_W-1:0]  len,
                                     input int unsigned       rows);
    logic [ADDR_W:0] last;
    last = {1'b0, addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, len};
    return last[ADDR_W] || (32'(last[ADDR_W-1:ROW_LSB]) >= rows);
  endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry read-return buffer between the SRAM data_out and the host read stream.
// Ports: in_vld/in_dat push (no ready; caller guarantees space), out_vld/out_rdy/out_dat pop, count = occupancy.
// Latency 1 cycle push-to-out_vld; push and pop in the same cycle are allowed; synchronous reset empties it.
module sram_rd_fifo #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         pop;

  assign out_vld = (count_q != 2'd0);
  assign out_dat = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign pop     = out_vld && out_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (in_vld) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, in_vld} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed when count_q says so.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sram_burst_ctl.sv
// Burst initiator for the sram macro: one host command becomes a linear burst of 1..256 beats.
// Latency: write beats reach the SRAM in the handshake cycle; first read beat 2 cycles after accept.
// Backpressure: wr_valid gaps stall the write pointer; rd_ready low stalls reads after 2 buffered beats.
// Ports: cmd_* host command, wr_* write beat stream, rd_* read beat stream, rsp_valid/rsp_err
// end-of-command pulse, busy, sram_* direct connection to the SRAM macro (1-cycle read latency).
module sram_burst_ctl
  import sram_ctl_pkg::*;
#(
  parameter int ROWS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic              busy,
  output logic [DATA_W-1:0] sram_data_in,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_write_en,
  input  logic [DATA_W-1:0] sram_data_out
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              inflight_q, inflight_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        fifo_count;
  logic              rd_pop;
  logic [2:0]        occ;
  logic              issue;

  // The in-flight read lands in the FIFO next cycle, so it already holds a slot.
  sram_rd_fifo #(
    .W (DATA_W)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (inflight_q),
    .in_dat  (sram_data_out),
    .out_vld (rd_valid),
    .out_rdy (rd_ready),
    .out_dat (rd_data),
    .count   (fifo_count)
  );

  assign rd_pop = rd_valid && rd_ready;
  // Occupancy after this cycle's pop: counting the pop is what lets a steady
  // rd_ready=1 stream issue every cycle instead of stalling on a full slot
  // that is leaving at the same edge.
  assign occ    = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, rd_pop};

  assign cmd_ready     = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign wr_ready      = (state_q == ST_WRITE);
  assign sram_write_en = wr_ready && wr_valid;
  assign sram_data_in  = wr_ready ? wr_data : '0;
  assign sram_address  = ptr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remain_d    = remain_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          ptr_d    = cmd_addr;
          remain_d = cmd_len;
          if (range_err(cmd_addr, cmd_len, ROWS)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = cmd_write ? ST_WRITE : ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (wr_valid) begin
          ptr_d    = ptr_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
          remain_d = remain_q - {{(LEN_W - 1){1'b0}}, 1'b1};
          if (remain_q == '0) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (occ < 3'd2) begin
          issue    = 1'b1;
          ptr_d    = ptr_q + {{(ADDR_W - 1){1'b0}}, 1'b1};
          remain_d = remain_q - {{(LEN_W - 1){1'b0}}, 1'b1};
          if (remain_q == '0) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (fifo_count == 2'd0)) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    inflight_d = issue;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remain_q    <= remain_d;
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: doc/sram_burst_ctl.md
# sram_burst_ctl

Burst initiator for the `sram` macro. It accepts single-command read or write bursts from a host over valid/ready handshakes and drives the SRAM's `data_in`/`address`/`write_en` ports one beat per cycle. It returns read data from the SRAM's 1-cycle-latency `data_out` through a backpressure-safe buffer. It sits between the host datapath and the `sram` instance.

## Interface
- `ROWS`, 1024: implemented rows per bank; valid row field `addr[22:5]` is 0..ROWS-1
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: reset is synchronous and active-high
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake
- `cmd_write` in 1: 1 = write burst, 0 = read burst
- `cmd_addr` in 23: first beat address; `[4:0]` bank, `[22:5]` row
- `cmd_len` in 8: beats minus one (1..256 beats)
- `wr_valid` in 1 / `wr_ready` out 1 / `wr_data` in 256: write beat stream
- `rd_valid` out 1 / `rd_ready` in 1 / `rd_data` out 256: read beat stream
- `rsp_valid` out 1: one-cycle end-of-command pulse
- `rsp_err` out 1: qualifies `rsp_valid`; 1 = range error, burst not executed
- `busy` out 1: state != IDLE
- `sram_data_in` out 256, `sram_address` out 23, `sram_write_en` out 1: to SRAM
- `sram_data_out` in 256: from SRAM; valid the cycle after the address is presented

## Operation
- States: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch `ptr`=`cmd_addr` and `remain`=`cmd_len`, then range-check.
- Range check: `last` = `cmd_addr` + `cmd_len` in 24 bits. Error if bit 23 carries or `last[22:5]` >= ROWS. Error goes to RESP with `rsp_err`=1, with no SRAM access.
- Linear increment: `ptr`+1 per beat. Bank field wraps into row field; there is no wrap at 2^23, which is an error case.
- WRITE: `wr_ready`=1. `sram_write_en` = `wr_valid`, `sram_address`=`ptr`, `sram_data_in`=`wr_data`. On each accepted beat, `ptr`++ and `remain`--. When `remain`==0 is accepted, go to RESP with `rsp_err`=0.
- READ: issue a read (present `ptr`, `sram_write_en`=0) only when FIFO count + in-flight < 2. Set in-flight flag; the next cycle pushes `sram_data_out` into the FIFO. After the last issue, go to DRAIN.
- DRAIN: wait until in-flight is 0 and the FIFO is empty, then go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- `rd_valid` = FIFO non-empty; pop on `rd_valid && rd_ready`. Push and pop in the same cycle is legal.
- `sram_address` = `ptr` in all states. `sram_write_en`=0 outside WRITE.
- Reset mid-burst: abort immediately. FIFO is flushed, the in-flight read is discarded, and no `rsp_valid` is sent for the aborted command.

## Timing
- Reset values: state IDLE, `cmd_ready`=1 after reset, `wr_ready`=0, `rd_valid`=0, `rsp_valid`=0, `rsp_err`=0, `busy`=0, `sram_write_en`=0, `sram_address`=0, `sram_data_in`=0, FIFO empty.
- Command accept at edge N: first WRITE/READ cycle is N+1. An error sets `rsp_valid` at N+1.
- Write: one beat per cycle while `wr_valid`=1. `rsp_valid` comes 1 cycle after the last beat.
- Read: first `rd_valid` 2 cycles after accept. Sustains 1 beat/cycle with `rd_ready` held at 1. With `rd_ready`=0, at most 2 beats buffered, then issue stalls.
- `wr_data`/`wr_valid` are not registered; SRAM captures at the same edge as the handshake.

## Structure
- `sram_ctl_pkg`: `ADDR_W`=23, `DATA_W`=256, `BANK_W`=5, `ROW_LSB`=5, state enum.
- One sub-module `sram_rd_fifo`: 2-entry, 256-bit, synchronous-reset FIFO with `count` output for credit logic.

## Test plan
- Write 4 beats at 0x000000 (data 0xA0..0xA3), then read 4 at 0x000000 with `rd_ready`=1: returns 0xA0..0xA3 back-to-back, one `rsp_valid` per command, `rsp_err`=0.
- Write across the bank-to-row carry, `addr`=0x00001E, `cmd_len`=3: beats land at 0x1E, 0x1F, 0x20, 0x21. Readback matches.
- `cmd_addr`=0x007FE0 (row 1023), `cmd_len`=31: accepted. The same address with `cmd_len`=32: `rsp_err`=1 one cycle after accept, with no `sram_write_en`.
- Read 8 beats with `rd_ready` toggling 1,0,0,1: no beat lost or duplicated, FIFO never exceeds 2, order preserved.
- Write 8 beats with `wr_valid` gaps: `sram_write_en` only on valid cycles, `ptr` advances only on accepted beats.
- Assert `rst` mid-read after 3 beats: next cycle IDLE, `rd_valid`=0, no `rsp_valid`. A new command then completes normally.
